// File: rtl/bellman_relax_pkg.sv
// bellman_relax_pkg: sizes, vertmat word layout and FSM states shared by the
// relaxation and cycle detection stages.
package bellman_relax_pkg;
   localparam int NODES        = 32;
   localparam int WEIGHT_WIDTH = 15;
   localparam int PRED_WIDTH   = 4;
   localparam int VERT_WIDTH   = 21;
   localparam int WEIGHT_LSB   = 0;
   localparam int PRED_LSB     = WEIGHT_WIDTH + 1;
   localparam int RSV_BIT      = VERT_WIDTH;

   typedef enum logic [2:0] {IDLE, INIT, READ, CHECK, WRITE, DONE} relax_state_t;

   typedef struct packed {
      logic                          rsv;
      logic [PRED_WIDTH:0]           pred;
      logic signed [WEIGHT_WIDTH:0]  weight;
   } vert_word_t;

   function automatic vert_word_t pack_vert(input logic [PRED_WIDTH:0] pred,
                                            input logic signed [WEIGHT_WIDTH:0] weight);
      return '{rsv: 1'b0, pred: pred, weight: weight};
   endfunction
endpackage

// File: rtl/bellman_relax_alu.sv
// relax_alu: decides whether edge e improves the destination weight and
// produces the candidate weight clamped to the signed weight range.
module relax_alu import bellman_relax_pkg::*; (
   input  logic signed [WEIGHT_WIDTH:0] svw,
   input  logic signed [WEIGHT_WIDTH:0] dvw,
   input  logic signed [WEIGHT_WIDTH:0] e,
   output logic                         relax,
   output logic signed [WEIGHT_WIDTH:0] sum_sat
);
   logic signed [WEIGHT_WIDTH+1:0] sum;
   assign sum     = {svw[WEIGHT_WIDTH], svw} + {e[WEIGHT_WIDTH], e};
   assign relax   = (e != '0) && (sum < $signed({dvw[WEIGHT_WIDTH], dvw}));
   // top two bits disagree only on overflow; clamp toward the sign of the true sum
   assign sum_sat = (sum[WEIGHT_WIDTH+1] != sum[WEIGHT_WIDTH])
                    ? {sum[WEIGHT_WIDTH+1], {WEIGHT_WIDTH{~sum[WEIGHT_WIDTH+1]}}}
                    : sum[WEIGHT_WIDTH:0];
endmodule

// File: rtl/bellman_relax.sv
// bellman_relax: Bellman-Ford over adjmat with a virtual source; fills vertmat
// with weights and predecessors, stopping early after a pass with no update.
module bellman_relax import bellman_relax_pkg::*; #(
   parameter int NODES = bellman_relax_pkg::NODES
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    relax_start,
   input  logic [WEIGHT_WIDTH:0]   adjmat_q,
   input  logic [VERT_WIDTH:0]     vertmat_q_a,
   input  logic [VERT_WIDTH:0]     vertmat_q_b,
   output logic [PRED_WIDTH:0]     adjmat_row_addr,
   output logic [PRED_WIDTH:0]     adjmat_col_addr,
   output logic [PRED_WIDTH:0]     vertmat_addr_a,
   output logic [PRED_WIDTH:0]     vertmat_addr_b,
   output logic [VERT_WIDTH:0]     vertmat_data_b,
   output logic                    vertmat_we_b,
   output logic                    relax_busy,
   output logic                    relax_done,
   output logic [PRED_WIDTH:0]     relax_passes
);
   localparam logic [PRED_WIDTH:0] LAST = (PRED_WIDTH+1)'(NODES - 1);

   relax_state_t                 state;
   logic [PRED_WIDTH:0]          i, j;
   logic                         upd, relax, last_edge, unused_bits;
   logic signed [WEIGHT_WIDTH:0] sat_sum, wsum;
   vert_word_t                   qa, qb;

   assign qa          = vert_word_t'(vertmat_q_a);
   assign qb          = vert_word_t'(vertmat_q_b);
   assign unused_bits = ^{qa.rsv, qa.pred, qb.rsv, qb.pred};

   relax_alu u_alu (
      .svw     (qa.weight),
      .dvw     (qb.weight),
      .e       (adjmat_q),
      .relax   (relax),
      .sum_sat (sat_sum)
   );

   // j doubles as the vertex counter during INIT, so port b always addresses j
   assign adjmat_row_addr = i;
   assign adjmat_col_addr = j;
   assign vertmat_addr_a  = i;
   assign vertmat_addr_b  = j;
   assign vertmat_we_b    = state == INIT || state == WRITE;
   assign vertmat_data_b  = state == INIT  ? pack_vert(j, '0)
                          : state == WRITE ? pack_vert(i, wsum) : '0;
   assign relax_busy      = state inside {INIT, READ, CHECK, WRITE};
   assign relax_done      = state == DONE;
   assign last_edge       = i == LAST && j == LAST;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= IDLE;
         i            <= '0;
         j            <= '0;
         upd          <= 1'b0;
         wsum         <= '0;
         relax_passes <= '0;
      end else
         case (state)
            IDLE, DONE:
               if (relax_start) begin
                  state        <= INIT;
                  i            <= '0;
                  j            <= '0;
                  upd          <= 1'b0;
                  relax_passes <= '0;
               end
            INIT: begin
               j <= j == LAST ? '0 : j + 1'b1;
               if (j == LAST) state <= READ;
            end
            READ: state <= CHECK;
            default:
               if (state == CHECK && relax) begin
                  state <= WRITE;
                  upd   <= 1'b1;
                  wsum  <= sat_sum;
               end else if (!last_edge) begin
                  j     <= j == LAST ? '0 : j + 1'b1;
                  i     <= j == LAST ? i + 1'b1 : i;
                  state <= READ;
               end else begin
                  relax_passes <= relax_passes + 1'b1;
                  if (!upd || relax_passes + 1'b1 == LAST)
                     state <= DONE;
                  else begin
                     upd   <= 1'b0;
                     i     <= '0;
                     j     <= '0;
                     state <= READ;
                  end
               end
         endcase
endmodule

// File: tb/tb_bellman_relax.sv
// tb_bellman_relax: directed scenarios on a 4-vertex instance with behavioural
// synchronous-read memories for adjmat and vertmat.
module tb_bellman_relax;
   localparam int N = 4;

   logic        clk = 0, reset_n = 0, relax_start = 0;
   logic [15:0] adjmat_q;
   logic [21:0] vertmat_q_a, vertmat_q_b, vertmat_data_b;
   logic [4:0]  adjmat_row_addr, adjmat_col_addr, vertmat_addr_a, vertmat_addr_b, relax_passes;
   logic        vertmat_we_b, relax_busy, relax_done;

   logic [15:0] adj [0:N-1][0:N-1];
   logic [21:0] vm  [0:N-1];
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   bellman_relax #(.NODES(N)) dut (
      .clk(clk), .reset_n(reset_n), .relax_start(relax_start), .adjmat_q(adjmat_q),
      .vertmat_q_a(vertmat_q_a), .vertmat_q_b(vertmat_q_b),
      .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr),
      .vertmat_addr_a(vertmat_addr_a), .vertmat_addr_b(vertmat_addr_b),
      .vertmat_data_b(vertmat_data_b), .vertmat_we_b(vertmat_we_b),
      .relax_busy(relax_busy), .relax_done(relax_done), .relax_passes(relax_passes)
   );

   always @(posedge clk) begin
      adjmat_q    <= adj[adjmat_row_addr[1:0]][adjmat_col_addr[1:0]];
      vertmat_q_a <= vm[vertmat_addr_a[1:0]];
      vertmat_q_b <= vm[vertmat_addr_b[1:0]];
      if (vertmat_we_b) vm[vertmat_addr_b[1:0]] <= vertmat_data_b;
   end

   function automatic logic [21:0] mkw(input logic [4:0] p, input logic [15:0] w);
      return {1'b0, p, w};
   endfunction

   task automatic clear_adj();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) adj[r][c] = 16'h0000;
   endtask

   task automatic run(output int cyc);
      @(negedge clk); relax_start = 1;
      @(posedge clk); #1; relax_start = 0; cyc = 1;
      while (!relax_done && cyc < 2000) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic test_reset();
      clear_adj();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (vertmat_we_b !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", vertmat_we_b); end
      n_cmp++; if (relax_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", relax_busy); end
      n_cmp++; if (relax_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", relax_done); end
      n_cmp++; if (relax_passes !== 5'd0) begin n_bad++; $display("FAIL reset_passes: got %0d want 0", relax_passes); end
      n_cmp++; if ({adjmat_row_addr, adjmat_col_addr, vertmat_addr_b} !== 15'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", {adjmat_row_addr, adjmat_col_addr, vertmat_addr_b}); end
      n_cmp++; if (vertmat_data_b !== 22'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", vertmat_data_b); end
      @(negedge clk); reset_n = 1;
   endtask

   task automatic test_empty();
      int cyc;
      clear_adj();
      run(cyc);
      n_cmp++; if (cyc !== 37) begin n_bad++; $display("FAIL empty_latency: got %0d want 37", cyc); end
      n_cmp++; if (relax_passes !== 5'd1) begin n_bad++; $display("FAIL empty_passes: got %0d want 1", relax_passes); end
      n_cmp++; if ({relax_done, relax_busy, vertmat_we_b} !== 3'b100) begin n_bad++; $display("FAIL empty_flags: got %b want 100", {relax_done, relax_busy, vertmat_we_b}); end
      n_cmp++; if ({adjmat_row_addr, adjmat_col_addr} !== {5'd3, 5'd3}) begin n_bad++; $display("FAIL empty_hold_addr: got %h want 63", {adjmat_row_addr, adjmat_col_addr}); end
      for (int k = 0; k < N; k++) begin
         n_cmp++; if (vm[k] !== mkw(5'(k), 16'h0000)) begin n_bad++; $display("FAIL empty_init_v%0d: got %h want %h", k, vm[k], mkw(5'(k), 16'h0000)); end
      end
   endtask

   task automatic test_chain();
      int cyc;
      clear_adj();
      adj[0][1] = 16'hFFFD;
      adj[1][2] = 16'hFFFC;
      run(cyc);
      n_cmp++; if (cyc !== 71) begin n_bad++; $display("FAIL chain_latency: got %0d want 71", cyc); end
      n_cmp++; if (relax_passes !== 5'd2) begin n_bad++; $display("FAIL chain_passes: got %0d want 2", relax_passes); end
      n_cmp++; if (vm[0] !== mkw(5'd0, 16'h0000)) begin n_bad++; $display("FAIL chain_v0: got %h want %h", vm[0], mkw(5'd0, 16'h0000)); end
      n_cmp++; if (vm[1] !== mkw(5'd0, 16'hFFFD)) begin n_bad++; $display("FAIL chain_v1: got %h want %h", vm[1], mkw(5'd0, 16'hFFFD)); end
      n_cmp++; if (vm[2] !== mkw(5'd1, 16'hFFF9)) begin n_bad++; $display("FAIL chain_v2: got %h want %h", vm[2], mkw(5'd1, 16'hFFF9)); end
      n_cmp++; if (vm[3] !== mkw(5'd3, 16'h0000)) begin n_bad++; $display("FAIL chain_v3: got %h want %h", vm[3], mkw(5'd3, 16'h0000)); end
   endtask

   task automatic test_neg_cycle();
      int cyc;
      clear_adj();
      adj[0][1] = 16'hFFFE;
      adj[1][0] = 16'h0001;
      run(cyc);
      n_cmp++; if (cyc !== 107) begin n_bad++; $display("FAIL negcyc_latency: got %0d want 107", cyc); end
      n_cmp++; if (relax_passes !== 5'd3) begin n_bad++; $display("FAIL negcyc_passes: got %0d want 3", relax_passes); end
      n_cmp++; if (vm[0] !== mkw(5'd1, 16'hFFFD)) begin n_bad++; $display("FAIL negcyc_v0: got %h want %h", vm[0], mkw(5'd1, 16'hFFFD)); end
      n_cmp++; if (vm[1] !== mkw(5'd0, 16'hFFFC)) begin n_bad++; $display("FAIL negcyc_v1: got %h want %h", vm[1], mkw(5'd0, 16'hFFFC)); end
   endtask

   task automatic test_saturation();
      int cyc;
      clear_adj();
      adj[0][1] = 16'h8000;
      adj[1][2] = 16'h8000;
      run(cyc);
      n_cmp++; if (relax_passes !== 5'd3) begin n_bad++; $display("FAIL sat_passes: got %0d want 3", relax_passes); end
      n_cmp++; if (vm[1] !== mkw(5'd0, 16'h8000)) begin n_bad++; $display("FAIL sat_v1: got %h want %h", vm[1], mkw(5'd0, 16'h8000)); end
      n_cmp++; if (vm[2] !== mkw(5'd1, 16'h8000)) begin n_bad++; $display("FAIL sat_v2: got %h want %h", vm[2], mkw(5'd1, 16'h8000)); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      clear_adj();
      adj[0][1] = 16'hFFFD;
      adj[1][2] = 16'hFFFC;
      @(negedge clk); relax_start = 1;
      @(posedge clk); #1; relax_start = 0; cyc = 1;
      while (!(vertmat_we_b && cyc > 5) && cyc < 200) begin @(posedge clk); #1; cyc++; end
      n_cmp++; if (!(cyc < 200)) begin n_bad++; $display("FAIL midrst_write_seen: got timeout at %0d want write before 200", cyc); end
      #2 reset_n = 0;
      #1;
      n_cmp++; if (vertmat_we_b !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %b want 0", vertmat_we_b); end
      n_cmp++; if ({relax_busy, relax_done} !== 2'b00) begin n_bad++; $display("FAIL midrst_flags: got %b want 00", {relax_busy, relax_done}); end
      n_cmp++; if (relax_passes !== 5'd0) begin n_bad++; $display("FAIL midrst_passes: got %0d want 0", relax_passes); end
      @(negedge clk); reset_n = 1;
      run(cyc);
      n_cmp++; if (cyc !== 71) begin n_bad++; $display("FAIL midrst_rerun_latency: got %0d want 71", cyc); end
      n_cmp++; if (relax_passes !== 5'd2) begin n_bad++; $display("FAIL midrst_rerun_passes: got %0d want 2", relax_passes); end
      n_cmp++; if (vm[2] !== mkw(5'd1, 16'hFFF9)) begin n_bad++; $display("FAIL midrst_rerun_v2: got %h want %h", vm[2], mkw(5'd1, 16'hFFF9)); end
   endtask

   task automatic test_start_ignore();
      int cyc;
      clear_adj();
      @(negedge clk); relax_start = 1;
      @(posedge clk); #1; relax_start = 0; cyc = 1;
      while (!relax_done && cyc < 2000) begin
         if (cyc == 2 || cyc == 5) relax_start = 1;
         @(posedge clk); #1; relax_start = 0; cyc++;
      end
      n_cmp++; if (cyc !== 37) begin n_bad++; $display("FAIL ignore_latency: got %0d want 37", cyc); end
      n_cmp++; if (relax_passes !== 5'd1) begin n_bad++; $display("FAIL ignore_passes: got %0d want 1", relax_passes); end
      @(negedge clk); relax_start = 1;
      @(posedge clk); #1; relax_start = 0; cyc = 1;
      n_cmp++; if ({relax_done, relax_busy, vertmat_we_b} !== 3'b011) begin n_bad++; $display("FAIL restart_flags: got %b want 011", {relax_done, relax_busy, vertmat_we_b}); end
      n_cmp++; if (relax_passes !== 5'd0) begin n_bad++; $display("FAIL restart_passes: got %0d want 0", relax_passes); end
      while (!relax_done && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      n_cmp++; if (cyc !== 37) begin n_bad++; $display("FAIL restart_latency: got %0d want 37", cyc); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_chain();
      test_neg_cycle();
      test_saturation();
      test_reset_mid();
      test_start_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bellman_relax.md
Name: bellman_relax

Overview:
Upstream relaxation stage that fills vertmat with shortest-path weights and predecessors, which the cycle detection stage then scans for negative cycles.
Runs Bellman-Ford over the adjacency matrix: initialises every vertex, then makes up to NODES-1 passes over all (i,j) edges, relaxing vertmat in place.
Exits early after a pass with no update. Asserts relax_done, which releases the cycle detection stage.

Parameters:
NODES, 32, vertex count; adjmat is NODES x NODES.
WEIGHT_WIDTH, 15, MSB index of signed weight (16-bit two's complement).
PRED_WIDTH, 4, MSB index of vertex index/predecessor field.
VERT_WIDTH, 21, MSB index of vertmat word.
Vertmat word layout: [WEIGHT_WIDTH:0] weight, [VERT_WIDTH-1:WEIGHT_WIDTH+1] predecessor, bit [VERT_WIDTH] reserved and written 0.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
relax_start  in  1  1-cycle pulse; starts a run; ignored unless in IDLE or DONE
adjmat_q  in  WEIGHT_WIDTH+1  signed edge weight at (row,col); 0 means no edge
vertmat_q_a  in  VERT_WIDTH+1  vertmat word at vertmat_addr_a (source vertex)
vertmat_q_b  in  VERT_WIDTH+1  vertmat word at vertmat_addr_b (destination vertex)
adjmat_row_addr  out  PRED_WIDTH+1  edge source i
adjmat_col_addr  out  PRED_WIDTH+1  edge destination j
vertmat_addr_a  out  PRED_WIDTH+1  equals i
vertmat_addr_b  out  PRED_WIDTH+1  equals j; init vertex index during INIT
vertmat_data_b  out  VERT_WIDTH+1  write data for port b
vertmat_we_b  out  1  write enable for port b
relax_busy  out  1  high from INIT through the last pass
relax_done  out  1  sticky; high in DONE until the next relax_start or reset
relax_passes  out  PRED_WIDTH+1  completed pass count of the current/last run

Behaviour:
- Reset (async, reset_n=0): state IDLE; i=j=0; relax_passes=0; all outputs 0.
- Memories have a synchronous read, 1-cycle latency. A write followed by a read of the same address returns the new data.
- IDLE/DONE: on relax_start go to INIT with v=0, and clear relax_done, relax_passes and the pass-updated flag. relax_start in any other state is ignored.
- INIT: one cycle per vertex. Drive vertmat_we_b=1, addr_b=v, data_b={0, pred=v, weight=0}. This is the virtual-source init: all weights 0, predecessor = self. After v=NODES-1, go to READ with i=j=0.
- READ: i and j are already driving the addresses. Go to CHECK next cycle.
- CHECK: e=adjmat_q, svw=q_a weight, dvw=q_b weight, all signed. sum = svw + e, computed in WEIGHT_WIDTH+2 bits, sign-extended.
  - If e!=0 and sum < dvw: go to WRITE and set the pass-updated flag.
  - Otherwise advance (i,j).
- WRITE: one cycle with we_b=1, addr_b=j, data_b={0, pred=i, weight=sat(sum)}. sat clamps to [-2^WEIGHT_WIDTH, 2^WEIGHT_WIDTH-1]. Then advance (i,j).
- Advance (i,j): j increments first and wraps to 0 with i+1. The diagonal is processed normally; its weight is 0, so it is skipped.
  - On (NODES-1, NODES-1), the pass ends: relax_passes+1.
  - If the pass-updated flag is 0, or relax_passes+1 == NODES-1, go to DONE.
  - Otherwise clear the flag, set i=j=0 and go to READ.
- Cost per edge: 2 cycles, or 3 with an update. Pass order is row-major ascending.
- DONE: relax_done=1, relax_busy=0, vertmat_we_b=0. Addresses are held at last values.
- vertmat_we_b is high only in INIT and WRITE.
- reset_n asserted mid-run aborts immediately to IDLE. Partial vertmat contents are undefined.

Decomposition:
- Shared package holds: NODES, WEIGHT_WIDTH, PRED_WIDTH, VERT_WIDTH; vertmat field offsets; the state enum; and a vert_word pack/unpack struct. The package is shared with the cycle detection stage.
- One natural sub-module: relax_alu (combinational). Takes svw, dvw and e; outputs the relax flag and saturated sum.

Test Plan:
- Empty adjmat, NODES=4, start at edge 0 -> INIT writes 4 words {w=0, pred=self}; one pass of 32 cycles; relax_done high 37 clk edges after start; relax_passes=1.
- Edges 0->1 = -3 and 1->2 = -4 -> after pass 1: v1 = {-3, pred 0} and v2 = {-7, pred 1}; pass 2 has no update; relax_passes=2.
- Negative cycle 0->1 = -2, 1->0 = 1, NODES=4 -> runs the full 3 passes; relax_passes=3; v0 weight < 0. The cycle detection stage flags a cycle.
- Saturation: 0->1 = -32768, 1->2 = -32768 -> v2 weight = -32768 (clamped), pred 1; no wrap to positive.
- Reset mid-pass: pull reset_n low asynchronously between clock edges during WRITE -> we_b drops immediately; state is IDLE; relax_done=0. A fresh relax_start then produces the same result as a clean run.
- relax_start pulsed during INIT and during READ -> ignored. Pulsed in DONE -> relax_done clears the next cycle and the run restarts.
